// File: rtl/wb_pkg.sv
// Shared widths, write-back source encodings and control payload for the write-back stage.
// The register-file enables are derived here so the collision rule lives in one place.
package wb_pkg;

  localparam int unsigned DATA_WIDTH     = 16;
  localparam int unsigned REG_ADDR_WIDTH = 3;
  localparam int unsigned WB_COUNT_WIDTH = 16;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef struct packed {
    logic valid;
    logic write_low;
    logic write_high;
  } wb_ctrl_t;

  localparam int unsigned WB_CTRL_WIDTH = $bits(wb_ctrl_t);

  // On a destination collision the low write wins and the high write is dropped.
  function automatic wb_ctrl_t wb_make_ctrl(
    input logic valid,
    input logic write_low,
    input logic write_high,
    input logic dst_match
  );
    wb_ctrl_t c;
    c.valid      = valid;
    c.write_low  = valid & write_low;
    c.write_high = valid & write_high & ~(write_low & write_high & dst_match);
    return c;
  endfunction

endpackage

// File: rtl/wb_pipe_reg.sv
// Pipeline register with async active-low clear, load enable and synchronous bubble load.
// Bubble load takes priority over the data input whenever the enable is set.
module wb_pipe_reg #(
  parameter int unsigned      WIDTH  = 1,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             bubble,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= bubble ? BUBBLE : d;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Memory-to-write-back pipeline stage: selects write data, resolves enable collisions and
// presents flop-direct register-file write ports plus a retired-instruction counter.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = wb_pkg::DATA_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = wb_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_valid,
  input  logic                      mem_reg_write_low,
  input  logic                      mem_reg_write_high,
  input  logic                      mem_wb_sel,
  input  logic [REG_ADDR_WIDTH-1:0] mem_reg_dst_low,
  input  logic [REG_ADDR_WIDTH-1:0] mem_reg_dst_high,
  input  logic [DATA_WIDTH-1:0]     mem_alu_low,
  input  logic [DATA_WIDTH-1:0]     mem_alu_high,
  input  logic [DATA_WIDTH-1:0]     mem_read_data,
  input  logic                      stall,
  input  logic                      flush,
  output logic                      reg_write_low,
  output logic                      reg_write_high,
  output logic [REG_ADDR_WIDTH-1:0] reg_dst_low,
  output logic [REG_ADDR_WIDTH-1:0] reg_dst_high,
  output logic [DATA_WIDTH-1:0]     data_to_be_written_low,
  output logic [DATA_WIDTH-1:0]     data_to_be_written_high,
  output logic                      wb_valid,
  output logic [WB_COUNT_WIDTH-1:0] wb_count
);

  localparam int unsigned IDX_WIDTH = 2 * REG_ADDR_WIDTH;
  localparam int unsigned DAT_WIDTH = 2 * DATA_WIDTH;

  logic                  load_en;
  logic                  count_inc;
  logic                  dst_match;
  wb_ctrl_t              ctrl_d;
  wb_ctrl_t              ctrl_q;
  logic [DATA_WIDTH-1:0] data_low_d;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [DAT_WIDTH-1:0]  dat_q;

  assign load_en   = ~stall | flush;
  assign count_inc = mem_valid & ~stall & ~flush;

  // All selection happens ahead of the flops so the outputs are pure flop outputs.
  always_comb begin
    dst_match  = (mem_reg_dst_low == mem_reg_dst_high);
    ctrl_d     = wb_make_ctrl(mem_valid, mem_reg_write_low, mem_reg_write_high, dst_match);
    data_low_d = (mem_wb_sel == WB_SEL_MEM) ? mem_read_data : mem_alu_low;
  end

  wb_pipe_reg #(
    .WIDTH (WB_CTRL_WIDTH)
  ) u_ctrl_reg (
    .clk    (clk),
    .reset  (reset),
    .en     (load_en),
    .bubble (flush),
    .d      (ctrl_d),
    .q      (ctrl_q)
  );

  wb_pipe_reg #(
    .WIDTH (IDX_WIDTH)
  ) u_idx_reg (
    .clk    (clk),
    .reset  (reset),
    .en     (load_en),
    .bubble (flush),
    .d      ({mem_reg_dst_low, mem_reg_dst_high}),
    .q      (idx_q)
  );

  wb_pipe_reg #(
    .WIDTH (DAT_WIDTH)
  ) u_data_reg (
    .clk    (clk),
    .reset  (reset),
    .en     (load_en),
    .bubble (flush),
    .d      ({data_low_d, mem_alu_high}),
    .q      (dat_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_count <= '0;
    end else if (count_inc) begin
      wb_count <= wb_count + WB_COUNT_WIDTH'(1);
    end
  end

  assign wb_valid                = ctrl_q.valid;
  assign reg_write_low           = ctrl_q.write_low;
  assign reg_write_high          = ctrl_q.write_high;
  assign reg_dst_low             = idx_q[IDX_WIDTH-1:REG_ADDR_WIDTH];
  assign reg_dst_high            = idx_q[REG_ADDR_WIDTH-1:0];
  assign data_to_be_written_low  = dat_q[DAT_WIDTH-1:DATA_WIDTH];
  assign data_to_be_written_high = dat_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: a behavioural model pushes expected outputs per
// driven slot; each scenario task pops and compares them one cycle later.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        mem_valid;
  logic        mem_reg_write_low;
  logic        mem_reg_write_high;
  logic        mem_wb_sel;
  logic [2:0]  mem_reg_dst_low;
  logic [2:0]  mem_reg_dst_high;
  logic [15:0] mem_alu_low;
  logic [15:0] mem_alu_high;
  logic [15:0] mem_read_data;
  logic        stall;
  logic        flush;
  logic        reg_write_low;
  logic        reg_write_high;
  logic [2:0]  reg_dst_low;
  logic [2:0]  reg_dst_high;
  logic [15:0] data_to_be_written_low;
  logic [15:0] data_to_be_written_high;
  logic        wb_valid;
  logic [15:0] wb_count;

  typedef struct packed {
    logic        v;
    logic        wl;
    logic        wh;
    logic        sel;
    logic [2:0]  dl;
    logic [2:0]  dh;
    logic [15:0] al;
    logic [15:0] ah;
    logic [15:0] rd;
    logic        st;
    logic        fl;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic        wl;
    logic        wh;
    logic [2:0]  dl;
    logic [2:0]  dh;
    logic [15:0] dlo;
    logic [15:0] dhi;
    logic [15:0] cnt;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   checks;
  int   errors;

  writeback_stage dut (
    .clk                     (clk),
    .reset                   (reset),
    .mem_valid               (mem_valid),
    .mem_reg_write_low       (mem_reg_write_low),
    .mem_reg_write_high      (mem_reg_write_high),
    .mem_wb_sel              (mem_wb_sel),
    .mem_reg_dst_low         (mem_reg_dst_low),
    .mem_reg_dst_high        (mem_reg_dst_high),
    .mem_alu_low             (mem_alu_low),
    .mem_alu_high            (mem_alu_high),
    .mem_read_data           (mem_read_data),
    .stall                   (stall),
    .flush                   (flush),
    .reg_write_low           (reg_write_low),
    .reg_write_high          (reg_write_high),
    .reg_dst_low             (reg_dst_low),
    .reg_dst_high            (reg_dst_high),
    .data_to_be_written_low  (data_to_be_written_low),
    .data_to_be_written_high (data_to_be_written_high),
    .wb_valid                (wb_valid),
    .wb_count                (wb_count)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic v, input logic wl, input logic wh, input logic sel,
                               input logic [2:0] dl, input logic [2:0] dh,
                               input logic [15:0] al, input logic [15:0] ah,
                               input logic [15:0] rd, input logic st, input logic fl);
    stim_t s;
    s.v = v; s.wl = wl; s.wh = wh; s.sel = sel; s.dl = dl; s.dh = dh;
    s.al = al; s.ah = ah; s.rd = rd; s.st = st; s.fl = fl;
    return s;
  endfunction

  // Drive one slot at the falling edge, update the model, push, advance to the next falling edge.
  task automatic step(input stim_t s);
    mem_valid = s.v; mem_reg_write_low = s.wl; mem_reg_write_high = s.wh; mem_wb_sel = s.sel;
    mem_reg_dst_low = s.dl; mem_reg_dst_high = s.dh; mem_alu_low = s.al; mem_alu_high = s.ah;
    mem_read_data = s.rd; stall = s.st; flush = s.fl;
    if (s.fl) begin
      m.valid = 1'b0; m.wl = 1'b0; m.wh = 1'b0;
    end else if (!s.st) begin
      m.valid = s.v;
      m.wl    = s.v & s.wl;
      m.wh    = s.v & s.wh & ~(s.wl & s.wh & (s.dl == s.dh));
      m.dl    = s.dl;
      m.dh    = s.dh;
      m.dlo   = s.sel ? s.rd : s.al;
      m.dhi   = s.ah;
      if (s.v) m.cnt = m.cnt + 16'd1;
    end
    sb.push_back(m);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({wb_valid, reg_write_low, reg_write_high, reg_dst_low, reg_dst_high,
         data_to_be_written_low, data_to_be_written_high, wb_count} !== 57'd0) begin
      errors++;
      $display("FAIL reset_state got v%b wl%b wh%b dl%h dh%h lo%h hi%h cnt%h want all zero",
               wb_valid, reg_write_low, reg_write_high, reg_dst_low, reg_dst_high,
               data_to_be_written_low, data_to_be_written_high, wb_count);
    end
    @(negedge clk);
    reset = 1'b1;
    m = '0;
  endtask

  task automatic test_alu_path();
    stim_t st[4];
    exp_t  e;
    st[0] = mk(1, 1, 0, 0, 3'd3, 3'd0, 16'h1234, 16'h0000, 16'hFFFF, 0, 0);
    st[1] = mk(1, 0, 1, 0, 3'd1, 3'd7, 16'h0F0F, 16'hCAFE, 16'h0000, 0, 0);
    st[2] = mk(0, 1, 1, 1, 3'd2, 3'd4, 16'h9999, 16'h8888, 16'h7777, 0, 0);
    st[3] = mk(1, 1, 0, 0, 3'd0, 3'd0, 16'h0001, 16'h0002, 16'h0003, 0, 0);
    foreach (st[i]) begin
      step(st[i]);
      e = sb.pop_front();
      checks++;
      if ({wb_valid, reg_write_low, reg_write_high, wb_count} !== {e.valid, e.wl, e.wh, e.cnt}) begin
        errors++;
        $display("FAIL alu_ctrl[%0d] got v%b wl%b wh%b cnt%h want v%b wl%b wh%b cnt%h", i,
                 wb_valid, reg_write_low, reg_write_high, wb_count, e.valid, e.wl, e.wh, e.cnt);
      end
      if (e.valid) begin
        checks++;
        if ({reg_dst_low, reg_dst_high, data_to_be_written_low, data_to_be_written_high} !==
            {e.dl, e.dh, e.dlo, e.dhi}) begin
          errors++;
          $display("FAIL alu_data[%0d] got dl%h dh%h lo%h hi%h want dl%h dh%h lo%h hi%h", i,
                   reg_dst_low, reg_dst_high, data_to_be_written_low, data_to_be_written_high,
                   e.dl, e.dh, e.dlo, e.dhi);
        end
      end
    end
  endtask

  task automatic test_collision();
    stim_t st[3];
    exp_t  e;
    st[0] = mk(1, 1, 1, 0, 3'd5, 3'd5, 16'hAAAA, 16'h5555, 16'h0000, 0, 0);
    st[1] = mk(1, 1, 1, 0, 3'd5, 3'd6, 16'hAAAA, 16'h5555, 16'h0000, 0, 0);
    st[2] = mk(1, 0, 1, 0, 3'd6, 3'd6, 16'h1357, 16'h2468, 16'h0000, 0, 0);
    foreach (st[i]) begin
      step(st[i]);
      e = sb.pop_front();
      checks++;
      if ({wb_valid, reg_write_low, reg_write_high, wb_count} !== {e.valid, e.wl, e.wh, e.cnt}) begin
        errors++;
        $display("FAIL collide_ctrl[%0d] got v%b wl%b wh%b cnt%h want v%b wl%b wh%b cnt%h", i,
                 wb_valid, reg_write_low, reg_write_high, wb_count, e.valid, e.wl, e.wh, e.cnt);
      end
      checks++;
      if ({reg_dst_low, reg_dst_high, data_to_be_written_low, data_to_be_written_high} !==
          {e.dl, e.dh, e.dlo, e.dhi}) begin
        errors++;
        $display("FAIL collide_data[%0d] got dl%h dh%h lo%h hi%h want dl%h dh%h lo%h hi%h", i,
                 reg_dst_low, reg_dst_high, data_to_be_written_low, data_to_be_written_high,
                 e.dl, e.dh, e.dlo, e.dhi);
      end
    end
  endtask

  task automatic test_load_stall_flush();
    stim_t st[6];
    exp_t  e;
    st[0] = mk(1, 1, 0, 1, 3'd2, 3'd0, 16'h1111, 16'h2222, 16'hBEEF, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      st[k] = mk(1, 1, 1, k[0], 3'(k), 3'(k + 3), 16'($urandom), 16'($urandom), 16'($urandom), 1, 0);
    end
    st[4] = mk(1, 1, 1, 0, 3'd4, 3'd1, 16'h4444, 16'h5555, 16'h6666, 1, 1);
    st[5] = mk(1, 1, 0, 0, 3'd7, 3'd1, 16'h7777, 16'h0000, 16'h0000, 0, 0);
    foreach (st[i]) begin
      step(st[i]);
      e = sb.pop_front();
      checks++;
      if ({wb_valid, reg_write_low, reg_write_high, wb_count} !== {e.valid, e.wl, e.wh, e.cnt}) begin
        errors++;
        $display("FAIL lsf_ctrl[%0d] got v%b wl%b wh%b cnt%h want v%b wl%b wh%b cnt%h", i,
                 wb_valid, reg_write_low, reg_write_high, wb_count, e.valid, e.wl, e.wh, e.cnt);
      end
      if (e.valid) begin
        checks++;
        if ({reg_dst_low, reg_dst_high, data_to_be_written_low, data_to_be_written_high} !==
            {e.dl, e.dh, e.dlo, e.dhi}) begin
          errors++;
          $display("FAIL lsf_data[%0d] got dl%h dh%h lo%h hi%h want dl%h dh%h lo%h hi%h", i,
                   reg_dst_low, reg_dst_high, data_to_be_written_low, data_to_be_written_high,
                   e.dl, e.dh, e.dlo, e.dhi);
        end
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    apply_reset();
    for (int k = 0; k < 65535; k++) begin
      step(mk(1, 1, 0, 0, 3'(k), 3'd0, 16'(k), 16'h0000, 16'h0000, 0, 0));
      e = sb.pop_front();
    end
    checks++;
    if (wb_count !== e.cnt) begin
      errors++;
      $display("FAIL wrap_preload got cnt%h want cnt%h", wb_count, e.cnt);
    end
    step(mk(1, 1, 0, 0, 3'd1, 3'd0, 16'hD00D, 16'h0000, 16'h0000, 0, 0));
    e = sb.pop_front();
    checks++;
    if ({wb_valid, reg_write_low, wb_count, data_to_be_written_low} !==
        {e.valid, e.wl, e.cnt, e.dlo}) begin
      errors++;
      $display("FAIL wrap_roll got v%b wl%b cnt%h lo%h want v%b wl%b cnt%h lo%h",
               wb_valid, reg_write_low, wb_count, data_to_be_written_low,
               e.valid, e.wl, e.cnt, e.dlo);
    end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    step(mk(1, 1, 1, 0, 3'd3, 3'd4, 16'h0BAD, 16'hF00D, 16'h0000, 0, 0));
    e = sb.pop_front();
    checks++;
    if ({wb_valid, reg_write_low, reg_write_high} !== {e.valid, e.wl, e.wh}) begin
      errors++;
      $display("FAIL midop_pre got v%b wl%b wh%b want v%b wl%b wh%b",
               wb_valid, reg_write_low, reg_write_high, e.valid, e.wl, e.wh);
    end
    mem_alu_low = 16'h5A5A;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({wb_valid, reg_write_low, reg_write_high, reg_dst_low, reg_dst_high,
         data_to_be_written_low, data_to_be_written_high, wb_count} !== 57'd0) begin
      errors++;
      $display("FAIL midop_async got v%b wl%b wh%b dl%h dh%h lo%h hi%h cnt%h want all zero",
               wb_valid, reg_write_low, reg_write_high, reg_dst_low, reg_dst_high,
               data_to_be_written_low, data_to_be_written_high, wb_count);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wb_valid, reg_write_low, wb_count} !== 18'd0) begin
      errors++;
      $display("FAIL midop_held got v%b wl%b cnt%h want all zero", wb_valid, reg_write_low, wb_count);
    end
    reset = 1'b1;
    m = '0;
    sb.delete();
    step(mk(1, 1, 0, 0, 3'd6, 3'd0, 16'h600D, 16'h0000, 16'h0000, 0, 0));
    e = sb.pop_front();
    checks++;
    if ({wb_valid, reg_write_low, reg_dst_low, data_to_be_written_low, wb_count} !==
        {e.valid, e.wl, e.dl, e.dlo, e.cnt}) begin
      errors++;
      $display("FAIL midop_first got v%b wl%b dl%h lo%h cnt%h want v%b wl%b dl%h lo%h cnt%h",
               wb_valid, reg_write_low, reg_dst_low, data_to_be_written_low, wb_count,
               e.valid, e.wl, e.dl, e.dlo, e.cnt);
    end
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0;
    mem_valid = 1'b0; mem_reg_write_low = 1'b0; mem_reg_write_high = 1'b0; mem_wb_sel = 1'b0;
    mem_reg_dst_low = '0; mem_reg_dst_high = '0; mem_alu_low = '0; mem_alu_high = '0;
    mem_read_data = '0; stall = 1'b0; flush = 1'b0;
    checks = 0; errors = 0; m = '0;
    test_reset();
    test_alu_path();
    test_collision();
    test_load_stall_flush();
    test_wrap();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
